// File: rtl/rot_sq_n.sv
// Rotating-square animator: one "o" glyph walks the perimeter of an N-digit
// seven-segment display, stepped by a runtime-programmable prescaler.
module rot_sq_n #(
  parameter  int DIGITS = 3,
  parameter  int DIV_W  = 24,
  localparam int P_W    = $clog2(2*DIGITS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_dir,
  input  logic [DIV_W-1:0]      i_step_div,
  output logic [5*DIGITS-1:0]   o_hex,
  output logic [P_W-1:0]        o_pos,
  output logic                  o_lap
);

  localparam logic [4:0]     BLANK = 5'b10010;
  localparam logic [4:0]     UPO   = 5'b10101;
  localparam logic [4:0]     LOWO  = 5'b10100;
  localparam logic [P_W-1:0] LAST  = P_W'(2*DIGITS-1);

  logic [DIV_W-1:0] r_cnt;
  logic [P_W-1:0]   r_pos;
  logic             r_lap;
  logic             w_step;
  logic             w_wrap;
  logic [P_W-1:0]   w_pos_nxt;

  assign w_step = i_enable && (r_cnt >= i_step_div);

  // ">=" lets a forced out-of-range position fall back to 0 going forward
  always_comb begin
    w_pos_nxt = r_pos;
    w_wrap    = 1'b0;
    if (i_dir) begin
      if (r_pos == '0) begin
        w_pos_nxt = LAST;
        w_wrap    = 1'b1;
      end else begin
        w_pos_nxt = r_pos - P_W'(1);
      end
    end else begin
      if (r_pos >= LAST) begin
        w_pos_nxt = '0;
        w_wrap    = 1'b1;
      end else begin
        w_pos_nxt = r_pos + P_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_pos <= '0;
      r_lap <= 1'b0;
    end else begin
      r_lap <= 1'b0;
      if (w_step) begin
        r_cnt <= '0;
        r_pos <= w_pos_nxt;
        r_lap <= w_wrap;
      end else if (i_enable) begin
        r_cnt <= r_cnt + DIV_W'(1);
      end
    end
  end

  // Digit k: upper row at p = k+1, lower row at p = 2*DIGITS-k (p = 0 for k = 0)
  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    logic w_up;
    logic w_low;
    assign w_up = (r_pos == P_W'(k+1));
    if (k == 0) begin : g_first
      assign w_low = (r_pos == '0);
    end else begin : g_rest
      assign w_low = (r_pos == P_W'(2*DIGITS-k));
    end
    assign o_hex[5*k +: 5] = w_up ? UPO : (w_low ? LOWO : BLANK);
  end

  assign o_pos = r_pos;
  assign o_lap = r_lap;

endmodule

// File: tb/tb_rot_sq_n.sv
// Directed bench for rot_sq_n: 3-digit and 8-digit instances share stimulus.
module tb_rot_sq_n;

  localparam logic [4:0] BLANK = 5'b10010;
  localparam logic [4:0] UPO   = 5'b10101;
  localparam logic [4:0] LOWO  = 5'b10100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        dir = 1'b0;
  logic [23:0] step_div = '0;
  logic [14:0] hex3;
  logic [2:0]  pos3;
  logic        lap3;
  logic [39:0] hex8;
  logic [3:0]  pos8;
  logic        lap8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rot_sq_n #(.DIGITS(3), .DIV_W(24)) u_dut3 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_dir(dir),
    .i_step_div(step_div), .o_hex(hex3), .o_pos(pos3), .o_lap(lap3));

  rot_sq_n #(.DIGITS(8), .DIV_W(24)) u_dut8 (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_dir(dir),
    .i_step_div(step_div), .o_hex(hex8), .o_pos(pos8), .o_lap(lap8));

  task automatic chk(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [39:0] model_hex(input int p, input int d);
    logic [39:0] h;
    h = '0;
    for (int k = 0; k < d; k++) h[5*k +: 5] = BLANK;
    if (p == 0)          h[4:0] = LOWO;
    else if (p <= d)     h[5*(p-1) +: 5] = UPO;
    else if (p < 2*d)    h[5*(2*d-p) +: 5] = LOWO;
    return h;
  endfunction

  function automatic int lit_count(input logic [39:0] h);
    int c;
    c = 0;
    for (int k = 0; k < 8; k++) if (h[5*k +: 5] != BLANK) c++;
    return c;
  endfunction

  initial begin
    // forward, step every cycle
    enable = 1'b1; dir = 1'b0; step_div = 24'd0;
    do_reset();
    chk("rst_pos", 40'(pos3), 40'd0);
    chk("rst_lap", 40'(lap3), 40'd0);
    chk("rst_hex", 40'(hex3), 40'({BLANK, BLANK, LOWO}));
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("fwd_pos", 40'(pos3), 40'(i % 6));
      chk("fwd_lap", 40'(lap3), 40'(i == 6));
      chk("fwd_hex", 40'(hex3), model_hex(i % 6, 3));
      if (i == 3) chk("hex_p3", 40'(hex3), 40'({UPO, BLANK, BLANK}));
      if (i == 5) chk("hex_p5", 40'(hex3), 40'({BLANK, LOWO, BLANK}));
    end

    // step_div=3 with an enable gap mid-period
    step_div = 24'd3;
    do_reset();
    tick(3);
    chk("div3_hold", 40'(pos3), 40'd0);
    tick();
    chk("div3_step", 40'(pos3), 40'd1);
    tick(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("frz_pos", 40'(pos3), 40'd1);
      chk("frz_lap", 40'(lap3), 40'd0);
    end
    chk("frz_hex", 40'(hex3), 40'({BLANK, BLANK, UPO}));
    enable = 1'b1;
    tick();
    chk("resume_hold", 40'(pos3), 40'd1);
    tick();
    chk("resume_step", 40'(pos3), 40'd2);

    // reverse, step every cycle
    step_div = 24'd0; dir = 1'b1;
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("rev_pos", 40'(pos3), 40'(6 - i));
      chk("rev_lap", 40'(lap3), 40'(i == 1));
      chk("rev_hex", 40'(hex3), model_hex(6 - i, 3));
      if (i == 1) chk("rev_hex_p5", 40'(hex3), 40'({BLANK, LOWO, BLANK}));
    end

    // step_div lowered below the running count
    dir = 1'b0; step_div = 24'd1000;
    do_reset();
    tick(500);
    chk("div1000_hold", 40'(pos3), 40'd0);
    step_div = 24'd100;
    tick();
    chk("div_drop_step", 40'(pos3), 40'd1);
    tick(100);
    chk("div100_hold", 40'(pos3), 40'd1);
    tick();
    chk("div100_step", 40'(pos3), 40'd2);
    tick(101);
    chk("div100_step2", 40'(pos3), 40'd3);

    // 8-digit full lap
    step_div = 24'd0; dir = 1'b0;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) tick();
      chk("d8_pos", 40'(pos8), 40'(i % 16));
      chk("d8_hex", hex8, model_hex(i % 16, 8));
      chk("d8_lit", 40'(lit_count(hex8)), 40'd1);
      chk("d8_lap", 40'(lap8), 40'(i == 16));
      if (i == 8) chk("d8_p8", hex8, {UPO, {7{BLANK}}});
      if (i == 9) chk("d8_p9", hex8, {LOWO, {7{BLANK}}});
    end

    // reset mid-period at pos 4
    step_div = 24'd3;
    do_reset();
    tick(16);
    chk("pre_rst_pos", 40'(pos3), 40'd4);
    tick(2);
    reset = 1'b1;
    tick();
    chk("mid_rst_pos", 40'(pos3), 40'd0);
    chk("mid_rst_lap", 40'(lap3), 40'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_hex", 40'(hex3), 40'({BLANK, BLANK, LOWO}));
    tick(2);
    chk("post_rst_hold", 40'(pos3), 40'd0);
    tick();
    chk("post_rst_step", 40'(pos3), 40'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
